// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller: FSM state
// encoding, access target decode and the memory-mapped UART addresses.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        TGT_SRAM,
        TGT_UART_DATA,
        TGT_UART_STAT
    } target_e;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side request/response bundle of the data-memory controller
// (exe_mem address/data in, load result and stall request out).
interface data_mem_ctrl_if;

    logic [15:0] Address;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] ReadData;
    logic        Busy;

    modport master (
        output Address, WriteData, MemRead, MemWrite,
        input  ReadData, Busy
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite,
        output ReadData, Busy
    );

endinterface

// File: rtl/data_mem_ctrl_strobe_timer.sv
// Strobe-width down-counter: reloads on load, saturates at zero, done at zero.
module strobe_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       count,
    input  logic [2:0] load_val,
    output logic       done
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && cnt_q != '0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: sequences SRAM (and, with UART_EN defined,
// memory-mapped UART) loads/stores and stalls the pipeline while busy.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave cpu,
    output logic [17:0]    ram1_addr,
    inout  wire  [15:0]    ram1_data,
    output logic           ram1_en_n,
    output logic           ram1_oe_n,
    output logic           ram1_we_n,
    output logic           uart_rdn,
    output logic           uart_wrn,
    input  logic           data_ready,
    input  logic           tbre,
    input  logic           tsre
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    target_e     tgt_q, tgt_d;
    logic [15:0] addr_q, wdata_q, rdata_q, rdata_d, stat_word;
    logic        en_n_q, oe_n_q, we_n_q, drive_q;
    logic        en_n_d, oe_n_d, we_n_d, drive_d;
    logic        tmr_load, tmr_done;

    assign tmr_load = (state_d != state_q);

    strobe_timer u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (tmr_load),
        .count    (~tmr_load),
        .load_val (WAIT_LOAD),
        .done     (tmr_done)
    );

    always_comb begin
        tgt_d = tgt_q;
        if (state_q == IDLE) begin
            tgt_d = TGT_SRAM;
`ifdef UART_EN
            if (cpu.Address == UART_DATA_ADDR) begin
                tgt_d = TGT_UART_DATA;
            end else if (cpu.Address == UART_STAT_ADDR) begin
                tgt_d = TGT_UART_STAT;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu.MemWrite) begin
                    state_d = WR_SETUP;
                end else if (cpu.MemRead) begin
                    state_d = RD;
                end
            end
            RD:       if (tmr_done) state_d = DONE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (tmr_done) state_d = WR_HOLD;
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they leave flops glitch-free.
    always_comb begin
        en_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        drive_d = 1'b0;
        case (state_d)
            RD: begin
                if (tgt_d == TGT_SRAM) begin
                    en_n_d = 1'b0;
                    oe_n_d = 1'b0;
                end
            end
            WR_SETUP, WR_HOLD: begin
                drive_d = (tgt_d != TGT_UART_STAT);
                en_n_d  = (tgt_d != TGT_SRAM);
            end
            WR_PULSE: begin
                drive_d = (tgt_d != TGT_UART_STAT);
                en_n_d  = (tgt_d != TGT_SRAM);
                we_n_d  = (tgt_d != TGT_SRAM);
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == RD && tmr_done) begin
            rdata_d = (tgt_q == TGT_UART_STAT) ? stat_word : ram1_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tgt_q   <= TGT_SRAM;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            rdata_q <= rdata_d;
            en_n_q  <= en_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
            if (state_q == IDLE && state_d != IDLE) begin
                addr_q  <= cpu.Address;
                wdata_q <= cpu.WriteData;
            end
        end
    end

`ifdef UART_EN
    logic rdn_q, wrn_q, rdn_d, wrn_d;

    always_comb begin
        rdn_d = 1'b1;
        wrn_d = 1'b1;
        if (tgt_d == TGT_UART_DATA) begin
            if (state_d == RD)       rdn_d = 1'b0;
            if (state_d == WR_PULSE) wrn_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdn_q <= 1'b1;
            wrn_q <= 1'b1;
        end else begin
            rdn_q <= rdn_d;
            wrn_q <= wrn_d;
        end
    end

    assign uart_rdn  = rdn_q;
    assign uart_wrn  = wrn_q;
    assign stat_word = {14'b0, data_ready, tbre & tsre};
`else
    logic unused_uart_status;
    assign unused_uart_status = &{1'b0, data_ready, tbre, tsre};
    assign uart_rdn  = 1'b1;
    assign uart_wrn  = 1'b1;
    assign stat_word = '0;
`endif

    // Busy is forced low during reset even if the pipeline still holds a request.
    assign cpu.Busy     = rst & ((state_q == IDLE) ? (cpu.MemRead | cpu.MemWrite)
                                                   : (state_q != DONE));
    assign cpu.ReadData = rdata_q;
    assign ram1_addr    = {2'b00, addr_q};
    assign ram1_en_n    = en_n_q;
    assign ram1_oe_n    = oe_n_q;
    assign ram1_we_n    = we_n_q;
    assign ram1_data    = drive_q ? wdata_q : 'z;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The module SHALL have the parameter WAIT_CYCLES, default 1, which sets the SRAM/UART strobe-low width in clk cycles (legal 1..7).
REQ-002 The module SHALL have the port clk, input, 1 bit: the single system clock.
REQ-003 The module SHALL have the port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The module SHALL have the port Address, input, 16 bits: the data address from the exe_mem register.
REQ-005 The module SHALL have the port WriteData, input, 16 bits: the store data.
REQ-006 The module SHALL have the ports MemRead and MemWrite, input, 1 bit each: the access requests, level-held by the pipeline.
REQ-007 The module SHALL have the port ReadData, output, 16 bits: the load result.
REQ-008 The module SHALL have the port Busy, output, 1 bit: the stall request to the PC, if/id, id/exe, exe/mem and mem/wb registers.
REQ-009 The module SHALL have the SRAM ports ram1_addr (output, 18 bits), ram1_data (inout, 16 bits), and ram1_en_n, ram1_oe_n and ram1_we_n (output, 1 bit each, active-low).
REQ-010 The module SHALL have the UART ports uart_rdn and uart_wrn (output, 1 bit each, active-low), and data_ready, tbre and tsre (input, 1 bit each).

Function
REQ-011 FSM states SHALL be IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-012 In IDLE, MemWrite=1 SHALL go to WR_SETUP; MemRead=1 alone SHALL go to RD; both asserted SHALL be treated as a write only.
REQ-013 RD SHALL drive ram1_oe_n=0 (or uart_rdn=0) for WAIT_CYCLES cycles, capture ram1_data into ReadData on the last RD cycle, then go to DONE.
REQ-014 WR_SETUP (1 cycle) SHALL drive ram1_data=WriteData with ram1_we_n=1.
REQ-015 WR_PULSE SHALL hold ram1_we_n=0 (or uart_wrn=0) for WAIT_CYCLES cycles.
REQ-016 WR_HOLD (1 cycle) SHALL keep data driven with ram1_we_n=1, then go to DONE.
REQ-017 DONE SHALL last 1 cycle and return unconditionally to IDLE; a request seen in the following IDLE cycle is a new access.
REQ-018 Busy SHALL be combinational: 1 in IDLE when MemRead|MemWrite, 1 in RD/WR_*, 0 in DONE and in idle IDLE.
REQ-019 Stall cycles at WAIT_CYCLES=1 SHALL be 2 for a load and 4 for a store.
REQ-020 ram1_addr SHALL be {2'b00, Address}, registered on IDLE exit and stable until DONE.
REQ-021 ram1_en_n SHALL be 0 only in RD/WR_* SRAM accesses.
REQ-022 ram1_data SHALL be high-Z except WR_SETUP..WR_HOLD.
REQ-023 ReadData SHALL hold its last value until the next load completes; stores SHALL NOT alter it.
REQ-024 The wait counter SHALL be 3 bits, reload to WAIT_CYCLES-1 on state entry, and never wrap.

Reset
REQ-025 rst=0 SHALL immediately force: state IDLE, ReadData=0, Busy=0, ram1_en_n=ram1_oe_n=ram1_we_n=1, uart_rdn=uart_wrn=1, ram1_data high-Z, counter 0.
REQ-026 Reset mid-access SHALL abort the access with no strobe glitch low; after release the pipeline's held request restarts from IDLE.

Configuration
REQ-027 With UART_EN defined, Address 0xBF00 SHALL map to the UART data register (strobes on uart_rdn/uart_wrn, SRAM untouched) and a read of 0xBF01 SHALL return {14'b0, data_ready, tbre&tsre} via RD with no strobe.
REQ-028 Without UART_EN, every address SHALL go to SRAM, uart_rdn/uart_wrn SHALL be tied 1, and the status inputs SHALL be ignored.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding, UART_DATA_ADDR=16'hBF00 and UART_STAT_ADDR=16'hBF01.
REQ-030 The strobe-width counter SHALL be one sub-module, strobe_timer (load, count, done).

Verification
REQ-031 Load from 0x0010 with SRAM model holding 0x1234 -> Busy high 2 cycles, ram1_oe_n low 1 cycle, ReadData=0x1234 in DONE.
REQ-032 Store 0xBEEF to 0x0020 -> ram1_we_n low exactly 1 cycle with data stable one cycle either side, Busy high 4 cycles, model reads back 0xBEEF.
REQ-033 MemRead=MemWrite=1 at 0x0030 with 0x5555 -> write performed, no oe pulse, ReadData unchanged.
REQ-034 rst low during WR_PULSE -> ram1_we_n=1 and bus high-Z in the same cycle, Busy=0, IDLE after release.
REQ-035 UART_EN, read 0xBF01 with data_ready=1, tbre=tsre=1 -> ReadData=0x0003, no uart_rdn pulse; write 0x0041 to 0xBF00 -> uart_wrn pulse, ram1_en_n stays 1.
REQ-036 WAIT_CYCLES=3 load -> ram1_oe_n low 3 cycles, Busy high 4 cycles.
